// File: rtl/avalon_burst_host_pkg.sv
// Shared types and constants for the Avalon-MM burst host.
package avalon_burst_host_pkg;

   typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_DATA, DONE} state_t;

   localparam int WORD_BYTES = 4;

   function automatic int max_burst(input int burstcount_w);
      return 1 << (burstcount_w - 1);
   endfunction

endpackage

// File: rtl/avalon_if.sv
// Avalon-MM bus bundle with a 32-bit data path; host and agent views.
interface avalon_if #(
   parameter int ADDR_W       = 32,
   parameter int BURSTCOUNT_W = 4
);
   logic [ADDR_W-1:0]       address;
   logic [BURSTCOUNT_W-1:0] burstcount;
   logic                    read;
   logic                    write;
   logic [31:0]             writedata;
   logic [3:0]              byteenable;
   logic [31:0]             readdata;
   logic                    readdatavalid;
   logic                    waitrequest;

   modport host (
      output address, burstcount, read, write, writedata, byteenable,
      input  readdata, readdatavalid, waitrequest
   );

   modport agent (
      input  address, burstcount, read, write, writedata, byteenable,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/burst_splitter.sv
// Tracks the running address and words remaining; presents the next burst length.
module burst_splitter
   import avalon_burst_host_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int BURSTCOUNT_W = 4,
   parameter int LEN_W        = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [ADDR_W-1:0]       load_address,
   input  logic [LEN_W-1:0]        load_len,
   input  logic                    burst_end,
   output logic [ADDR_W-1:0]       address,
   output logic [BURSTCOUNT_W-1:0] burst_len,
   output logic                    last_burst
);
   localparam int MAX_BURST = max_burst(BURSTCOUNT_W);

   logic [ADDR_W-1:0]       address_reg;
   logic [LEN_W-1:0]        remaining_reg;
   logic [LEN_W-1:0]        remaining_next;
   logic [BURSTCOUNT_W-1:0] burst_len_reg;

   function automatic logic [BURSTCOUNT_W-1:0] clip(input logic [LEN_W-1:0] n);
      if (n < LEN_W'(MAX_BURST))
         return BURSTCOUNT_W'(n);
      return BURSTCOUNT_W'(MAX_BURST);
   endfunction

   assign remaining_next = remaining_reg - LEN_W'(burst_len_reg);

   // Burst length is registered so burstcount never glitches while a burst is live.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         address_reg   <= '0;
         remaining_reg <= '0;
         burst_len_reg <= BURSTCOUNT_W'(1);
      end else if (load) begin
         address_reg   <= load_address;
         remaining_reg <= load_len;
         burst_len_reg <= clip(load_len);
      end else if (burst_end) begin
         address_reg   <= address_reg + ADDR_W'(burst_len_reg) * ADDR_W'(WORD_BYTES);
         remaining_reg <= remaining_next;
         burst_len_reg <= clip(remaining_next);
      end
   end

   assign address    = address_reg;
   assign burst_len  = burst_len_reg;
   assign last_burst = (remaining_reg == LEN_W'(burst_len_reg));
endmodule

// File: rtl/avalon_burst_host.sv
// Splits word-count commands into Avalon-MM bursts, one burst in flight at a time.
// Define AVALON_BURST_HOST_BE_EN to add cmd_byteenable for masked writes.
module avalon_burst_host
   import avalon_burst_host_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int BURSTCOUNT_W = 4,
   parameter int LEN_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic [LEN_W-1:0]  cmd_len,
`ifdef AVALON_BURST_HOST_BE_EN
   input  logic [3:0]        cmd_byteenable,
`endif
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [31:0]       wr_data,
   output logic              rd_valid,
   output logic [31:0]       rd_data,
   output logic              done,
   avalon_if.host            avalon_h
);
   state_t                  state;
   logic                    read_reg;
   logic                    done_reg;
   logic                    cmd_ready_reg;
   logic [BURSTCOUNT_W-1:0] beat_cnt;
   logic [BURSTCOUNT_W-1:0] burst_len;
   logic [ADDR_W-1:0]       burst_address;
   logic                    last_burst;
   logic                    load;
   logic                    beat;
   logic                    last_beat;
   logic                    burst_end;
   logic                    write_now;
   logic [3:0]              wr_be;
   logic [1:0]              unused_addr_bits;

   assign unused_addr_bits = cmd_address[1:0];
   assign load      = cmd_valid && cmd_ready_reg;
   assign write_now = (state == WR) && wr_valid;
   assign beat      = (write_now && !avalon_h.waitrequest) ||
                      ((state == RD_DATA) && avalon_h.readdatavalid);
   assign last_beat = (beat_cnt == burst_len - BURSTCOUNT_W'(1));
   assign burst_end = beat && last_beat;

   burst_splitter #(
      .ADDR_W       (ADDR_W),
      .BURSTCOUNT_W (BURSTCOUNT_W),
      .LEN_W        (LEN_W)
   ) u_splitter (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .load_address ({cmd_address[ADDR_W-1:2], 2'b00}),
      .load_len     (cmd_len),
      .burst_end    (burst_end),
      .address      (burst_address),
      .burst_len    (burst_len),
      .last_burst   (last_burst)
   );

`ifdef AVALON_BURST_HOST_BE_EN
   logic [3:0] be_reg;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         be_reg <= 4'hF;
      else if (load)
         be_reg <= cmd_byteenable;
   end
   assign wr_be = be_reg;
`else
   assign wr_be = 4'hF;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         read_reg      <= 1'b0;
         done_reg      <= 1'b0;
         cmd_ready_reg <= 1'b1;
         beat_cnt      <= '0;
      end else begin
         done_reg <= 1'b0;
         if (beat)
            beat_cnt <= last_beat ? '0 : beat_cnt + BURSTCOUNT_W'(1);
         case (state)
            IDLE: if (load) begin
               cmd_ready_reg <= 1'b0;
               beat_cnt      <= '0;
               if (cmd_len == '0) begin
                  state    <= DONE;
                  done_reg <= 1'b1;
               end else if (cmd_write) begin
                  state <= WR;
               end else begin
                  state    <= RD_REQ;
                  read_reg <= 1'b1;
               end
            end
            WR: if (burst_end && last_burst) begin
               state    <= DONE;
               done_reg <= 1'b1;
            end
            RD_REQ: if (!avalon_h.waitrequest) begin
               read_reg <= 1'b0;
               state    <= RD_DATA;
            end
            // Next read request goes out only once the previous burst has fully returned.
            RD_DATA: if (burst_end) begin
               if (last_burst) begin
                  state    <= DONE;
                  done_reg <= 1'b1;
               end else begin
                  state    <= RD_REQ;
                  read_reg <= 1'b1;
               end
            end
            DONE: begin
               state         <= IDLE;
               cmd_ready_reg <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_ready           = cmd_ready_reg;
   assign done                = done_reg;
   assign wr_ready            = write_now && !avalon_h.waitrequest;
   assign rd_valid            = (state == RD_DATA) && avalon_h.readdatavalid;
   assign rd_data             = rd_valid ? avalon_h.readdata : 32'h0;
   assign avalon_h.address    = burst_address;
   assign avalon_h.burstcount = burst_len;
   assign avalon_h.read       = read_reg;
   assign avalon_h.write      = write_now;
   assign avalon_h.writedata  = wr_data;
   assign avalon_h.byteenable = (state == WR) ? wr_be : 4'hF;
endmodule
